// File: rtl/mem_pkg.sv
// Shared types for the MEM-stage load/store unit: access sizes, fault codes and FSM states.
package mem_pkg;

  typedef enum logic [1:0] {MEM_B, MEM_H, MEM_W, MEM_D} mem_size_t;

  typedef enum logic [1:0] {FLT_NONE, FLT_MISALIGN, FLT_BUS, FLT_TIMEOUT} mem_fault_t;

  typedef enum logic [2:0] {ST_IDLE, ST_AR, ST_R, ST_AWW, ST_B, ST_FIN} lsu_state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store data/strobe placement and load extract with zero/sign extension.
module mem_lane_align import mem_pkg::*; #(
  parameter  int DATA_W = 32,
  localparam int NB     = DATA_W / 8,
  localparam int OFS_W  = $clog2(NB)
) (
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  input  logic [OFS_W-1:0]  ofs,
  input  logic [DATA_W-1:0] st_data,
  output logic [DATA_W-1:0] st_wdata,
  output logic [NB-1:0]     st_wstrb,
  input  logic [DATA_W-1:0] ld_rdata,
  output logic [DATA_W-1:0] ld_result
);

  int                nbytes;
  logic [DATA_W-1:0] shifted;

  always_comb begin
    nbytes    = 1 << size;
    // An illegal dword on a 32-bit bus is faulted upstream; clamp so indexing stays in range.
    if (nbytes > NB) nbytes = NB;
    st_wdata  = st_data << {ofs, 3'b000};
    st_wstrb  = '0;
    for (int b = 0; b < NB; b++) begin
      st_wstrb[b] = (b >= int'(ofs)) && (b < int'(ofs) + nbytes);
    end
    shifted   = ld_rdata >> {ofs, 3'b000};
    ld_result = '0;
    for (int i = 0; i < DATA_W; i++) begin
      ld_result[i] = (i < 8 * nbytes) ? shifted[i] : (!is_unsigned && shifted[8 * nbytes - 1]);
    end
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: one request in, one aligned AXI4-Lite transaction out, result to WB.
// Handshake: a transfer happens on a cycle where valid && ready; valid is held until then.
module mem_lsu import mem_pkg::*; #(
  parameter  int          DATA_W  = 32,
  parameter  int          ADDR_W  = 32,
  parameter  int unsigned TIMEOUT = 1023,
  localparam int          NB      = DATA_W / 8,
  localparam int          OFS_W   = $clog2(NB)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_load,
  input  logic              req_store,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic [ADDR_W-1:0] axi_araddr,
  output logic [2:0]        axi_arprot,
  output logic              axi_arvalid,
  input  logic              axi_arready,
  input  logic [DATA_W-1:0] axi_rdata,
  input  logic [1:0]        axi_rresp,
  input  logic              axi_rvalid,
  output logic              axi_rready,
  output logic [ADDR_W-1:0] axi_awaddr,
  output logic [2:0]        axi_awprot,
  output logic              axi_awvalid,
  input  logic              axi_awready,
  output logic [DATA_W-1:0] axi_wdata,
  output logic [NB-1:0]     axi_wstrb,
  output logic              axi_wvalid,
  input  logic              axi_wready,
  input  logic [1:0]        axi_bresp,
  input  logic              axi_bvalid,
  output logic              axi_bready,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [1:0]        fault_cause,
  output lsu_state_t        dbg_state
);

  lsu_state_t        state_q, state_d;
  mem_fault_t        fault_q, fault_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, result_q, result_d;
  logic [NB-1:0]     wstrb_q, wstrb_d;
  logic [1:0]        size_q, size_d;
  logic [OFS_W-1:0]  ofs_q, ofs_d;
  logic              uns_q, uns_d;
  logic              arvalid_q, arvalid_d, rready_q, rready_d;
  logic              awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic              done_q, done_d;
  logic [31:0]       tmo_q, tmo_d;

  logic              accept, misalign, timed_out, aw_left, w_left;
  logic [OFS_W-1:0]  req_ofs, al_ofs;
  logic [1:0]        al_size;
  logic [DATA_W-1:0] al_wdata, al_rdata;
  logic [NB-1:0]     al_wstrb;

  // In IDLE the aligner works on the incoming request; afterwards on the captured one.
  assign req_ofs = req_addr[OFS_W-1:0];
  assign al_size = (state_q == ST_IDLE) ? req_size : size_q;
  assign al_ofs  = (state_q == ST_IDLE) ? req_ofs : ofs_q;

  mem_lane_align #(.DATA_W(DATA_W)) u_align (
    .size        (al_size),
    .is_unsigned (uns_q),
    .ofs         (al_ofs),
    .st_data     (req_wdata),
    .st_wdata    (al_wdata),
    .st_wstrb    (al_wstrb),
    .ld_rdata    (axi_rdata),
    .ld_result   (al_rdata)
  );

  always_comb begin
    req_ready = (state_q == ST_IDLE);
    accept    = req_valid && req_ready;
    misalign  = ((int'(req_ofs) % (1 << req_size)) != 0) || (req_size == 2'd3 && DATA_W == 32);
    timed_out = (TIMEOUT != 0) && (32'(tmo_q + 32'd1) == 32'(TIMEOUT));
    aw_left   = awvalid_q && !axi_awready;
    w_left    = wvalid_q && !axi_wready;
    state_d   = state_q;
    fault_d   = fault_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    result_d  = result_q;
    size_d    = size_q;
    ofs_d     = ofs_q;
    uns_d     = uns_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    done_d    = 1'b0;
    tmo_d     = tmo_q + 32'd1;
    case (state_q)
      ST_IDLE: if (accept) begin
        addr_d   = req_addr & ~ADDR_W'(NB - 1);
        result_d = DATA_W'(req_addr);
        fault_d  = FLT_NONE;
        size_d   = req_size;
        ofs_d    = req_ofs;
        uns_d    = req_unsigned;
        tmo_d    = '0;
        if (!req_load && !req_store) begin
          done_d = 1'b1;
        end else if (misalign) begin
          fault_d = FLT_MISALIGN;
          done_d  = 1'b1;
        end else if (req_load) begin
          arvalid_d = 1'b1;
          state_d   = ST_AR;
        end else begin
          wdata_d   = al_wdata;
          wstrb_d   = al_wstrb;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = ST_AWW;
        end
      end
      ST_AR: if (axi_arready) begin
        arvalid_d = 1'b0;
        rready_d  = 1'b1;
        tmo_d     = '0;
        state_d   = ST_R;
      end else if (timed_out) begin
        arvalid_d = 1'b0;
        fault_d   = FLT_TIMEOUT;
        done_d    = 1'b1;
        state_d   = ST_IDLE;
      end
      ST_R: if (axi_rvalid || timed_out) begin
        rready_d = 1'b0;
        done_d   = 1'b1;
        state_d  = ST_IDLE;
        if (!axi_rvalid) fault_d = FLT_TIMEOUT;
        else if (axi_rresp[1]) begin
          fault_d  = FLT_BUS;
          result_d = '0;
        end else result_d = al_rdata;
      end
      ST_AWW: begin
        awvalid_d = aw_left;
        wvalid_d  = w_left;
        if (!aw_left && !w_left) begin
          bready_d = 1'b1;
          tmo_d    = '0;
          state_d  = ST_B;
        end else if (timed_out) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b0;
          fault_d   = FLT_TIMEOUT;
          done_d    = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_B: if (axi_bvalid || timed_out) begin
        bready_d = 1'b0;
        done_d   = 1'b1;
        state_d  = ST_IDLE;
        if (!axi_bvalid) fault_d = FLT_TIMEOUT;
        else if (axi_bresp[1]) fault_d = FLT_BUS;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      fault_q   <= FLT_NONE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      result_q  <= '0;
      size_q    <= '0;
      ofs_q     <= '0;
      uns_q     <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      done_q    <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      fault_q   <= fault_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      result_q  <= result_d;
      size_q    <= size_d;
      ofs_q     <= ofs_d;
      uns_q     <= uns_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      done_q    <= done_d;
      tmo_q     <= tmo_d;
    end
  end

  assign axi_araddr  = addr_q;
  assign axi_awaddr  = addr_q;
  assign axi_arprot  = 3'b000;
  assign axi_awprot  = 3'b000;
  assign axi_arvalid = arvalid_q;
  assign axi_rready  = rready_q;
  assign axi_awvalid = awvalid_q;
  assign axi_wvalid  = wvalid_q;
  assign axi_wdata   = wdata_q;
  assign axi_wstrb   = wstrb_q;
  assign axi_bready  = bready_q;
  assign done        = done_q;
  assign result      = result_q;
  assign fault_cause = fault_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: a 32-bit instance and a 64-bit instance, both with TIMEOUT=15.
module tb_mem_lsu;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // 32-bit instance
  logic        n_req_valid = 0, n_req_ready, n_req_load = 0, n_req_store = 0, n_req_unsigned = 0;
  logic [1:0]  n_req_size = 0;
  logic [31:0] n_req_addr = 0, n_req_wdata = 0;
  logic [31:0] n_araddr, n_awaddr, n_rdata = 0, n_wdata, n_result;
  logic [2:0]  n_arprot, n_awprot;
  logic        n_arvalid, n_arready = 0, n_rvalid = 0, n_rready, n_awvalid, n_awready = 0;
  logic        n_wvalid, n_wready = 0, n_bvalid = 0, n_bready, n_done;
  logic [1:0]  n_rresp = 0, n_bresp = 0, n_fault;
  logic [3:0]  n_wstrb;
  lsu_state_t  n_state;

  mem_lsu #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(15)) u_dut32 (
    .clk(clk), .rstn(rstn), .req_valid(n_req_valid), .req_ready(n_req_ready),
    .req_load(n_req_load), .req_store(n_req_store), .req_size(n_req_size),
    .req_unsigned(n_req_unsigned), .req_addr(n_req_addr), .req_wdata(n_req_wdata),
    .axi_araddr(n_araddr), .axi_arprot(n_arprot), .axi_arvalid(n_arvalid), .axi_arready(n_arready),
    .axi_rdata(n_rdata), .axi_rresp(n_rresp), .axi_rvalid(n_rvalid), .axi_rready(n_rready),
    .axi_awaddr(n_awaddr), .axi_awprot(n_awprot), .axi_awvalid(n_awvalid), .axi_awready(n_awready),
    .axi_wdata(n_wdata), .axi_wstrb(n_wstrb), .axi_wvalid(n_wvalid), .axi_wready(n_wready),
    .axi_bresp(n_bresp), .axi_bvalid(n_bvalid), .axi_bready(n_bready),
    .done(n_done), .result(n_result), .fault_cause(n_fault), .dbg_state(n_state)
  );

  // 64-bit instance
  logic        w_req_valid = 0, w_req_ready, w_req_load = 0, w_req_store = 0, w_req_unsigned = 0;
  logic [1:0]  w_req_size = 0;
  logic [31:0] w_req_addr = 0, w_araddr, w_awaddr;
  logic [63:0] w_req_wdata = 0, w_rdata = 0, w_wdata, w_result;
  logic [2:0]  w_arprot, w_awprot;
  logic        w_arvalid, w_arready = 0, w_rvalid = 0, w_rready, w_awvalid, w_awready = 0;
  logic        w_wvalid, w_wready = 0, w_bvalid = 0, w_bready, w_done;
  logic [1:0]  w_rresp = 0, w_bresp = 0, w_fault;
  logic [7:0]  w_wstrb;
  lsu_state_t  w_state;

  mem_lsu #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(15)) u_dut64 (
    .clk(clk), .rstn(rstn), .req_valid(w_req_valid), .req_ready(w_req_ready),
    .req_load(w_req_load), .req_store(w_req_store), .req_size(w_req_size),
    .req_unsigned(w_req_unsigned), .req_addr(w_req_addr), .req_wdata(w_req_wdata),
    .axi_araddr(w_araddr), .axi_arprot(w_arprot), .axi_arvalid(w_arvalid), .axi_arready(w_arready),
    .axi_rdata(w_rdata), .axi_rresp(w_rresp), .axi_rvalid(w_rvalid), .axi_rready(w_rready),
    .axi_awaddr(w_awaddr), .axi_awprot(w_awprot), .axi_awvalid(w_awvalid), .axi_awready(w_awready),
    .axi_wdata(w_wdata), .axi_wstrb(w_wstrb), .axi_wvalid(w_wvalid), .axi_wready(w_wready),
    .axi_bresp(w_bresp), .axi_bvalid(w_bvalid), .axi_bready(w_bready),
    .done(w_done), .result(w_result), .fault_cause(w_fault), .dbg_state(w_state)
  );

  // Drivers: called at a negedge, present one request, return at the negedge after the accept edge.
  task automatic n_issue(input logic ld, input logic st, input logic [1:0] sz, input logic un,
                         input logic [31:0] addr, input logic [31:0] wd);
    n_req_valid = 1; n_req_load = ld; n_req_store = st; n_req_size = sz;
    n_req_unsigned = un; n_req_addr = addr; n_req_wdata = wd;
    @(negedge clk);
    n_req_valid = 0; n_req_load = 0; n_req_store = 0;
  endtask

  task automatic w_issue(input logic ld, input logic st, input logic [1:0] sz, input logic un,
                         input logic [31:0] addr, input logic [63:0] wd);
    w_req_valid = 1; w_req_load = ld; w_req_store = st; w_req_size = sz;
    w_req_unsigned = un; w_req_addr = addr; w_req_wdata = wd;
    @(negedge clk);
    w_req_valid = 0; w_req_load = 0; w_req_store = 0;
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if ({n_arvalid, n_rready, n_awvalid, n_wvalid, n_bready, n_done} !== 6'b0 ||
        n_result !== 32'h0 || n_fault !== 2'b00 || n_wstrb !== 4'h0 || n_araddr !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs: valids=%b result=%h fault=%b required all zero",
               {n_arvalid, n_rready, n_awvalid, n_wvalid, n_bready, n_done}, n_result, n_fault);
    end
    @(negedge clk); rstn = 1;
    @(negedge clk);
    checks++;
    if (n_req_ready !== 1'b1 || w_req_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready: got %b/%b required 1/1", n_req_ready, w_req_ready);
    end
  endtask

  task automatic test_load_byte;
    n_issue(1, 0, 2'd0, 0, 32'h1003, 32'h0);
    checks++;
    if (n_arvalid !== 1'b1 || n_araddr !== 32'h1000 || n_req_ready !== 1'b0) begin
      failures++; $display("FAIL lb_ar: arvalid=%b araddr=%h ready=%b required 1 00001000 0",
                           n_arvalid, n_araddr, n_req_ready);
    end
    n_arready = 1; @(negedge clk); n_arready = 0;
    checks++;
    if (n_arvalid !== 1'b0 || n_rready !== 1'b1 || n_done !== 1'b0) begin
      failures++; $display("FAIL lb_r: arvalid=%b rready=%b done=%b required 0 1 0",
                           n_arvalid, n_rready, n_done);
    end
    n_rvalid = 1; n_rdata = 32'h80FF1234; n_rresp = 2'b00; @(negedge clk); n_rvalid = 0;
    checks++;
    if (n_done !== 1'b1 || n_result !== 32'hFFFFFF80 || n_fault !== 2'b00 || n_rready !== 1'b0) begin
      failures++; $display("FAIL lb_done: done=%b result=%h fault=%b rready=%b required 1 ffffff80 00 0",
                           n_done, n_result, n_fault, n_rready);
    end
    // Unsigned halfword from the upper half of the same beat.
    n_issue(1, 0, 2'd1, 1, 32'h1002, 32'h0);
    n_arready = 1; @(negedge clk); n_arready = 0;
    n_rvalid = 1; @(negedge clk); n_rvalid = 0;
    checks++;
    if (n_done !== 1'b1 || n_result !== 32'h000080FF) begin
      failures++; $display("FAIL lhu: done=%b result=%h required 1 000080ff", n_done, n_result);
    end
  endtask

  task automatic test_store_half;
    n_issue(0, 1, 2'd1, 0, 32'h2002, 32'h0000ABCD);
    checks++;
    if (n_awvalid !== 1'b1 || n_wvalid !== 1'b1 || n_awaddr !== 32'h2000 ||
        n_wdata !== 32'hABCD0000 || n_wstrb !== 4'b1100) begin
      failures++; $display("FAIL sh_aw: awv=%b wv=%b awaddr=%h wdata=%h wstrb=%b required 1 1 2000 abcd0000 1100",
                           n_awvalid, n_wvalid, n_awaddr, n_wdata, n_wstrb);
    end
    n_awready = 1; @(negedge clk); n_awready = 0;
    @(negedge clk);
    checks++;
    if (n_awvalid !== 1'b0 || n_wvalid !== 1'b1 || n_bready !== 1'b0) begin
      failures++; $display("FAIL sh_wait_w: awv=%b wv=%b bready=%b required 0 1 0",
                           n_awvalid, n_wvalid, n_bready);
    end
    n_wready = 1; @(negedge clk); n_wready = 0;
    checks++;
    if (n_wvalid !== 1'b0 || n_bready !== 1'b1 || n_done !== 1'b0) begin
      failures++; $display("FAIL sh_b: wv=%b bready=%b done=%b required 0 1 0", n_wvalid, n_bready, n_done);
    end
    n_bvalid = 1; n_bresp = 2'b00; @(negedge clk); n_bvalid = 0;
    checks++;
    if (n_done !== 1'b1 || n_bready !== 1'b0 || n_fault !== 2'b00) begin
      failures++; $display("FAIL sh_done: done=%b bready=%b fault=%b required 1 0 00", n_done, n_bready, n_fault);
    end
    @(negedge clk);
    checks++;
    if (n_done !== 1'b0) begin
      failures++; $display("FAIL sh_single_done: done=%b required 0", n_done);
    end
  endtask

  task automatic test_misaligned;
    n_issue(1, 0, 2'd2, 0, 32'h1001, 32'h0);
    checks++;
    if (n_done !== 1'b1 || n_fault !== 2'b01 || n_result !== 32'h1001 ||
        n_arvalid !== 1'b0 || n_awvalid !== 1'b0) begin
      failures++; $display("FAIL lw_misalign: done=%b fault=%b result=%h arv=%b awv=%b required 1 01 1001 0 0",
                           n_done, n_fault, n_result, n_arvalid, n_awvalid);
    end
    n_issue(0, 1, 2'd3, 0, 32'h1000, 32'h0);
    checks++;
    if (n_done !== 1'b1 || n_fault !== 2'b01 || n_awvalid !== 1'b0) begin
      failures++; $display("FAIL sd_on_32: done=%b fault=%b awv=%b required 1 01 0", n_done, n_fault, n_awvalid);
    end
  endtask

  task automatic test_back_to_back;
    n_issue(1, 0, 2'd1, 0, 32'h1003, 32'h0);
    checks++;
    if (n_done !== 1'b1 || n_req_ready !== 1'b1 || n_fault !== 2'b01) begin
      failures++; $display("FAIL b2b_first: done=%b ready=%b fault=%b required 1 1 01", n_done, n_req_ready, n_fault);
    end
    n_issue(0, 0, 2'd0, 0, 32'h0000_0055, 32'h0);
    checks++;
    if (n_done !== 1'b1 || n_fault !== 2'b00 || n_result !== 32'h55) begin
      failures++; $display("FAIL b2b_noop: done=%b fault=%b result=%h required 1 00 00000055",
                           n_done, n_fault, n_result);
    end
  endtask

  task automatic test_bus_error;
    n_issue(1, 0, 2'd2, 0, 32'h2000, 32'h0);
    n_arready = 1; @(negedge clk); n_arready = 0;
    n_rvalid = 1; n_rresp = 2'b10; n_rdata = 32'h12345678; @(negedge clk);
    n_rvalid = 0; n_rresp = 2'b00;
    checks++;
    if (n_done !== 1'b1 || n_fault !== 2'b10 || n_result !== 32'h0) begin
      failures++; $display("FAIL rresp_err: done=%b fault=%b result=%h required 1 10 0", n_done, n_fault, n_result);
    end
  endtask

  task automatic test_timeout;
    int  rcnt = 0;
    logic seen = 0;
    n_issue(1, 0, 2'd2, 0, 32'h0, 32'h0);
    n_arready = 1; @(negedge clk); n_arready = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (n_done) seen = 1;
      else begin
        if (n_rready) rcnt++;
        @(negedge clk);
      end
    end
    checks++;
    if (!seen || rcnt != 15 || n_fault !== 2'b11 || n_rready !== 1'b0) begin
      failures++; $display("FAIL timeout: seen=%b rready_cycles=%0d fault=%b rready=%b required 1 15 11 0",
                           seen, rcnt, n_fault, n_rready);
    end
    n_rvalid = 1; @(negedge clk); n_rvalid = 0;
    checks++;
    if (n_done !== 1'b0 || n_fault !== 2'b11) begin
      failures++; $display("FAIL stray_r: done=%b fault=%b required 0 11", n_done, n_fault);
    end
    n_issue(0, 0, 2'd0, 0, 32'h0000_0077, 32'h0);
    checks++;
    if (n_done !== 1'b1 || n_result !== 32'h77 || n_fault !== 2'b00) begin
      failures++; $display("FAIL after_timeout: done=%b result=%h fault=%b required 1 00000077 00",
                           n_done, n_result, n_fault);
    end
  endtask

  task automatic test_reset_in_b;
    int dcnt = 0;
    n_issue(0, 1, 2'd2, 0, 32'h3000, 32'hCAFEF00D);
    n_awready = 1; n_wready = 1; @(negedge clk); n_awready = 0; n_wready = 0;
    checks++;
    if (n_bready !== 1'b1) begin
      failures++; $display("FAIL rst_b_pre: bready=%b required 1", n_bready);
    end
    #2 rstn = 0;
    #1;
    checks++;
    if (n_bready !== 1'b0 || n_done !== 1'b0) begin
      failures++; $display("FAIL rst_b_async: bready=%b done=%b required 0 0", n_bready, n_done);
    end
    @(negedge clk); rstn = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (n_done) dcnt++;
    end
    checks++;
    if (dcnt != 0 || n_req_ready !== 1'b1) begin
      failures++; $display("FAIL rst_b_post: done_pulses=%0d ready=%b required 0 1", dcnt, n_req_ready);
    end
  endtask

  task automatic test_wide;
    w_issue(1, 0, 2'd2, 1, 32'hC, 64'h0);
    checks++;
    if (w_arvalid !== 1'b1 || w_araddr !== 32'h8) begin
      failures++; $display("FAIL w_lwu_ar: arvalid=%b araddr=%h required 1 00000008", w_arvalid, w_araddr);
    end
    w_arready = 1; @(negedge clk); w_arready = 0;
    w_rvalid = 1; w_rdata = 64'hDEADBEEF_00000000; @(negedge clk); w_rvalid = 0;
    checks++;
    if (w_done !== 1'b1 || w_result !== 64'h00000000_DEADBEEF) begin
      failures++; $display("FAIL w_lwu: done=%b result=%h required 1 00000000deadbeef", w_done, w_result);
    end
    w_issue(1, 0, 2'd2, 0, 32'hC, 64'h0);
    w_arready = 1; @(negedge clk); w_arready = 0;
    w_rvalid = 1; @(negedge clk); w_rvalid = 0;
    checks++;
    if (w_done !== 1'b1 || w_result !== 64'hFFFFFFFF_DEADBEEF) begin
      failures++; $display("FAIL w_lw: done=%b result=%h required 1 ffffffffdeadbeef", w_done, w_result);
    end
    w_issue(0, 1, 2'd3, 0, 32'h8, 64'h01234567_89ABCDEF);
    checks++;
    if (w_awaddr !== 32'h8 || w_wstrb !== 8'hFF || w_wdata !== 64'h01234567_89ABCDEF || w_awvalid !== 1'b1) begin
      failures++; $display("FAIL w_sd: awaddr=%h wstrb=%h wdata=%h awv=%b required 8 ff 0123456789abcdef 1",
                           w_awaddr, w_wstrb, w_wdata, w_awvalid);
    end
    w_awready = 1; w_wready = 1; @(negedge clk); w_awready = 0; w_wready = 0;
    w_bvalid = 1; w_bresp = 2'b10; @(negedge clk); w_bvalid = 0; w_bresp = 2'b00;
    checks++;
    if (w_done !== 1'b1 || w_fault !== 2'b10 || w_bready !== 1'b0) begin
      failures++; $display("FAIL w_sd_bresp: done=%b fault=%b bready=%b required 1 10 0", w_done, w_fault, w_bready);
    end
  endtask

  initial begin
    test_reset();
    test_load_byte();
    test_store_half();
    test_misaligned();
    test_back_to_back();
    test_bus_error();
    test_timeout();
    test_reset_in_b();
    test_wide();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
